hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage CPU, instanced beside the ID stage.
- Decides every stall, bubble and flush for the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC.
- Inputs: ID source-register usage, in-flight destinations in EX and MEM, ID branch resolution, and the data-memory ready handshake.
- Tracks the current hazard class in a small FSM, times out hung memory accesses, and flags them.

Parameters:
- MEM_TIMEOUT, 255: consecutive MEM_WAIT cycles before mem_timeout is raised (1..65535).
- CNT_W, 16: width of the internal wait counter; must hold MEM_TIMEOUT.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- ID_valid  in  1  ID holds a real instruction (0 = bubble)
- ID_rA  in  5  source A register
- ID_rA_used  in  1  instruction reads rA
- ID_rB  in  5  second source (rB, or rD for store/branch)
- ID_rB_used  in  1  instruction reads second source
- ID_is_branch  in  1  bez/bnez in ID
- ID_br_taken  in  1  branch condition true (from br_ctrl)
- EX_rD  in  5  EX destination
- EX_wrEn  in  1  EX writes RF
- EX_memEn  in  1  EX accesses memory
- EX_memwrEn  in  1  EX access is a store
- MEM_rD  in  5  MEM destination
- MEM_wrEn  in  1  MEM writes RF
- MEM_memEn  in  1  MEM stage has a memory access outstanding
- dmem_ready  in  1  data memory completes access this cycle
- PC_hold  out  1  PC keeps value
- IF_ID_hold  out  1  IF/ID keeps value
- IF_ID_flush  out  1  IF/ID loads a bubble
- ID_EX_bubble  out  1  ID/EX loads a bubble
- EX_MEM_hold  out  1  EX/MEM and ID/EX keep value
- MEM_WB_bubble  out  1  MEM/WB loads a bubble
- hdu_state  out  2  registered FSM state
- mem_timeout  out  1  sticky error flag
- stall_cycles  out  32  perf counter (see Optional Feature)

Behaviour:
- Hazard terms (combinational, all 32 registers compared; no r0 special case):
  - srcA = ID_valid & ID_rA_used; srcB = ID_valid & ID_rB_used.
  - load_haz = EX_memEn & ~EX_memwrEn & EX_wrEn & ((srcA & EX_rD==ID_rA) | (srcB & EX_rD==ID_rB)).
  - br_haz = ID_valid & ID_is_branch & ID_rB_used & ((EX_wrEn & EX_rD==ID_rB) | (MEM_wrEn & MEM_rD==ID_rB)). The branch reads the RF directly; WB write-through is sufficient.
  - mem_wait = MEM_memEn & ~dmem_ready.
- Priority: mem_wait > br_haz > load_haz > branch taken > none.
- Outputs by decision (all unlisted outputs 0):
  - mem_wait: PC_hold, IF_ID_hold, EX_MEM_hold, MEM_WB_bubble all 1.
  - br_haz: PC_hold, IF_ID_hold, ID_EX_bubble all 1. No flush; the branch re-resolves next cycle.
  - load_haz: PC_hold, IF_ID_hold, ID_EX_bubble all 1.
  - ID_valid & ID_is_branch & ID_br_taken, no hazard: IF_ID_flush=1 for exactly that cycle.
- Stall/flush outputs are combinational, with zero-cycle latency from inputs. While reset is high, all outputs are forced 0.
- FSM (registered, next state = decision class):
  - States: RUN=0, LD_STALL=1, BR_STALL=2, MEM_WAIT=3.
  - Reset value: RUN.
  - hdu_state shows the class of the previous cycle.
- Wait counter:
  - Increments (saturating at 2^CNT_W-1) each cycle mem_wait=1.
  - Clears on any cycle mem_wait=0.
  - When it increments to MEM_TIMEOUT, mem_timeout sets.
  - mem_timeout stays 1 until reset.
  - The stall continues regardless of the flag.
- Reset mid-stall: next cycle state=RUN, counter=0, mem_timeout=0, all outputs 0.
- A load followed by its consumer stalls exactly one cycle; a branch dependent on a load stalls until the load leaves MEM (BR_STALL for 2 cycles with no memory wait).

Optional Feature:
- Macro: HDU_PERF_CNT_EN.
- Defined: stall_cycles counts cycles with PC_hold=1, saturates at 0xFFFFFFFF, and is cleared by reset only.
- Undefined: the counter logic is absent and stall_cycles is tied to 0. The port is always present.

Test Plan:
- Load r3 in EX (memEn=1, memwrEn=0, wrEn=1, rD=3), ID add reads rA=3 -> PC_hold=IF_ID_hold=ID_EX_bubble=1 for one cycle; hdu_state=1 next cycle, then 0.
- bez on rB=5 with EX_rD=5 wrEn=1, then MEM_rD=5 next cycle -> PC_hold=1 for 2 cycles, no IF_ID_flush. On the third cycle with ID_br_taken=1 -> IF_ID_flush=1 for one cycle.
- MEM_memEn=1, dmem_ready=0 for 4 cycles while a load hazard is also present -> EX_MEM_hold=MEM_WB_bubble=1 and ID_EX_bubble=0 for all 4 cycles; hdu_state=3.
- MEM_TIMEOUT=8, dmem_ready held 0 -> mem_timeout rises at the 8th wait cycle and stays 1 after dmem_ready=1; reset clears it.
- Reset asserted during MEM_WAIT -> all outputs 0 while reset is high; after release, hdu_state=0 and the counter restarts from 0.
- With HDU_PERF_CNT_EN defined, run scenarios 1 and 2 back-to-back -> stall_cycles=3. Without the macro -> stall_cycles=0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Stall, bubble and flush sequencing for the 5-stage pipeline, with a memory-wait timeout.
// Optional HDU_PERF_CNT_EN adds a saturating count of PC-hold cycles on stall_cycles.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ID_valid,
  input  logic [4:0]  ID_rA,
  input  logic        ID_rA_used,
  input  logic [4:0]  ID_rB,
  input  logic        ID_rB_used,
  input  logic        ID_is_branch,
  input  logic        ID_br_taken,
  input  logic [4:0]  EX_rD,
  input  logic        EX_wrEn,
  input  logic        EX_memEn,
  input  logic        EX_memwrEn,
  input  logic [4:0]  MEM_rD,
  input  logic        MEM_wrEn,
  input  logic        MEM_memEn,
  input  logic        dmem_ready,
  output logic        PC_hold,
  output logic        IF_ID_hold,
  output logic        IF_ID_flush,
  output logic        ID_EX_bubble,
  output logic        EX_MEM_hold,
  output logic        MEM_WB_bubble,
  output logic [1:0]  hdu_state,
  output logic        mem_timeout,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    BR_STALL = 2'd2,
    MEM_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(MEM_TIMEOUT);

  state_t           r_state;
  state_t           w_next_state;
  logic             w_src_a;
  logic             w_src_b;
  logic             w_load_haz;
  logic             w_br_haz;
  logic             w_mem_wait;
  logic             w_br_flush;
  logic [CNT_W-1:0] r_wait_cnt;
  logic [CNT_W-1:0] w_wait_inc;
  logic             r_timeout;

  assign w_src_a    = ID_valid & ID_rA_used;
  assign w_src_b    = ID_valid & ID_rB_used;
  assign w_load_haz = EX_memEn & ~EX_memwrEn & EX_wrEn &
                      ((w_src_a & (EX_rD == ID_rA)) | (w_src_b & (EX_rD == ID_rB)));
  // The branch reads the register file in ID, so any producer still in EX or MEM blocks it.
  assign w_br_haz   = ID_valid & ID_is_branch & ID_rB_used &
                      ((EX_wrEn & (EX_rD == ID_rB)) | (MEM_wrEn & (MEM_rD == ID_rB)));
  assign w_mem_wait = MEM_memEn & ~dmem_ready;
  assign w_br_flush = ID_valid & ID_is_branch & ID_br_taken;

  always_comb begin
    w_next_state  = RUN;
    PC_hold       = 1'b0;
    IF_ID_hold    = 1'b0;
    IF_ID_flush   = 1'b0;
    ID_EX_bubble  = 1'b0;
    EX_MEM_hold   = 1'b0;
    MEM_WB_bubble = 1'b0;
    if (!reset) begin
      if (w_mem_wait) begin
        w_next_state  = MEM_WAIT;
        PC_hold       = 1'b1;
        IF_ID_hold    = 1'b1;
        EX_MEM_hold   = 1'b1;
        MEM_WB_bubble = 1'b1;
      end else if (w_br_haz) begin
        w_next_state = BR_STALL;
        PC_hold      = 1'b1;
        IF_ID_hold   = 1'b1;
        ID_EX_bubble = 1'b1;
      end else if (w_load_haz) begin
        w_next_state = LD_STALL;
        PC_hold      = 1'b1;
        IF_ID_hold   = 1'b1;
        ID_EX_bubble = 1'b1;
      end else if (w_br_flush) begin
        IF_ID_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next_state;
    end
  end

  assign w_wait_inc = (r_wait_cnt == CNT_MAX) ? r_wait_cnt : r_wait_cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else if (w_mem_wait) begin
      r_wait_cnt <= w_wait_inc;
      if (w_wait_inc == TIMEOUT_VAL) begin
        r_timeout <= 1'b1;
      end
    end else begin
      r_wait_cnt <= '0;
    end
  end

  assign hdu_state   = reset ? RUN : r_state;
  assign mem_timeout = r_timeout & ~reset;

`ifdef HDU_PERF_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (PC_hold && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cycles = reset ? 32'd0 : r_stall_cnt;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, branch, memory-wait, timeout and reset cases.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        ID_valid;
  logic [4:0]  ID_rA;
  logic        ID_rA_used;
  logic [4:0]  ID_rB;
  logic        ID_rB_used;
  logic        ID_is_branch;
  logic        ID_br_taken;
  logic [4:0]  EX_rD;
  logic        EX_wrEn;
  logic        EX_memEn;
  logic        EX_memwrEn;
  logic [4:0]  MEM_rD;
  logic        MEM_wrEn;
  logic        MEM_memEn;
  logic        dmem_ready;
  logic        PC_hold;
  logic        IF_ID_hold;
  logic        IF_ID_flush;
  logic        ID_EX_bubble;
  logic        EX_MEM_hold;
  logic        MEM_WB_bubble;
  logic [1:0]  hdu_state;
  logic        mem_timeout;
  logic [31:0] stall_cycles;

  int n_checks = 0;
  int n_errors = 0;

  hazard_ctrl #(.MEM_TIMEOUT(8), .CNT_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .ID_valid     (ID_valid),
    .ID_rA        (ID_rA),
    .ID_rA_used   (ID_rA_used),
    .ID_rB        (ID_rB),
    .ID_rB_used   (ID_rB_used),
    .ID_is_branch (ID_is_branch),
    .ID_br_taken  (ID_br_taken),
    .EX_rD        (EX_rD),
    .EX_wrEn      (EX_wrEn),
    .EX_memEn     (EX_memEn),
    .EX_memwrEn   (EX_memwrEn),
    .MEM_rD       (MEM_rD),
    .MEM_wrEn     (MEM_wrEn),
    .MEM_memEn    (MEM_memEn),
    .dmem_ready   (dmem_ready),
    .PC_hold      (PC_hold),
    .IF_ID_hold   (IF_ID_hold),
    .IF_ID_flush  (IF_ID_flush),
    .ID_EX_bubble (ID_EX_bubble),
    .EX_MEM_hold  (EX_MEM_hold),
    .MEM_WB_bubble(MEM_WB_bubble),
    .hdu_state    (hdu_state),
    .mem_timeout  (mem_timeout),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    ID_valid = 0; ID_rA = 0; ID_rA_used = 0; ID_rB = 0; ID_rB_used = 0;
    ID_is_branch = 0; ID_br_taken = 0;
    EX_rD = 0; EX_wrEn = 0; EX_memEn = 0; EX_memwrEn = 0;
    MEM_rD = 0; MEM_wrEn = 0; MEM_memEn = 0; dmem_ready = 1;
  endtask

  task automatic set_load_haz(input logic [4:0] r);
    EX_memEn = 1; EX_memwrEn = 0; EX_wrEn = 1; EX_rD = r;
    ID_valid = 1; ID_rA = r; ID_rA_used = 1;
  endtask

  // Stall outputs as a packed vector {PC, IFID_hold, IFID_flush, IDEX_bub, EXMEM_hold, MEMWB_bub}.
  function automatic logic [31:0] ctl();
    return {26'd0, PC_hold, IF_ID_hold, IF_ID_flush, ID_EX_bubble, EX_MEM_hold, MEM_WB_bubble};
  endfunction

  initial begin
    logic [31:0] exp_stalls;
`ifdef HDU_PERF_CNT_EN
    exp_stalls = 32'd3;
`else
    exp_stalls = 32'd0;
`endif

    // Reset with a hazard present: everything forced low.
    clear_inputs();
    reset = 1;
    set_load_haz(5'd7);
    tick(); tick();
    check("rst_ctl", ctl(), 32'h00);
    check("rst_state", {30'd0, hdu_state}, 32'd0);
    check("rst_timeout", {31'd0, mem_timeout}, 32'd0);
    clear_inputs();
    tick();
    reset = 0;
    settle();
    check("post_rst_state", {30'd0, hdu_state}, 32'd0);
    check("post_rst_stalls", stall_cycles, 32'd0);

    // Load r3 followed by an add reading r3: one-cycle stall.
    set_load_haz(5'd3);
    settle();
    check("ld_ctl", ctl(), 32'b110100);
    tick();
    EX_memEn = 0; EX_wrEn = 0;
    MEM_rD = 3; MEM_wrEn = 1; MEM_memEn = 1; dmem_ready = 1;
    settle();
    check("ld_release_ctl", ctl(), 32'h00);
    check("ld_state", {30'd0, hdu_state}, 32'd1);
    tick();
    clear_inputs();
    settle();
    check("ld_state_back", {30'd0, hdu_state}, 32'd0);

    // Branch on r5 dependent on a load: two stall cycles, then a taken flush.
    ID_valid = 1; ID_is_branch = 1; ID_rB_used = 1; ID_rB = 5;
    EX_rD = 5; EX_wrEn = 1; EX_memEn = 1;
    settle();
    check("br_ctl_1", ctl(), 32'b110100);
    tick();
    EX_wrEn = 0; EX_memEn = 0;
    MEM_rD = 5; MEM_wrEn = 1; MEM_memEn = 1; dmem_ready = 1;
    settle();
    check("br_ctl_2", ctl(), 32'b110100);
    check("br_state", {30'd0, hdu_state}, 32'd2);
    tick();
    MEM_wrEn = 0; MEM_memEn = 0; ID_br_taken = 1;
    settle();
    check("br_flush_ctl", ctl(), 32'b001000);
    check("br_state_2", {30'd0, hdu_state}, 32'd2);
    tick();
    clear_inputs();
    settle();
    check("br_flush_gone", ctl(), 32'h00);
    check("br_state_run", {30'd0, hdu_state}, 32'd0);
    check("stall_cycles", stall_cycles, exp_stalls);

    // Non-hazards and the r0 case.
    set_load_haz(5'd4); EX_memwrEn = 1;
    settle();
    check("store_no_haz", ctl(), 32'h00);
    clear_inputs(); set_load_haz(5'd4); ID_rA_used = 0;
    settle();
    check("unused_src_no_haz", ctl(), 32'h00);
    clear_inputs(); set_load_haz(5'd4); ID_valid = 0;
    settle();
    check("bubble_no_haz", ctl(), 32'h00);
    clear_inputs(); set_load_haz(5'd0);
    settle();
    check("r0_haz", ctl(), 32'b110100);
    clear_inputs(); set_load_haz(5'd9); ID_rA_used = 0;
    ID_rB = 9; ID_rB_used = 1;
    settle();
    check("srcB_haz", ctl(), 32'b110100);
    clear_inputs();
    tick();

    // Memory wait outranks a simultaneous load hazard.
    set_load_haz(5'd6);
    MEM_memEn = 1; dmem_ready = 0;
    settle();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("memwait_ctl_%0d", i), ctl(), 32'b110011);
      if (i > 0) check($sformatf("memwait_state_%0d", i), {30'd0, hdu_state}, 32'd3);
      tick();
    end
    dmem_ready = 1;
    settle();
    check("memwait_done_ctl", ctl(), 32'b110100);
    check("memwait_done_state", {30'd0, hdu_state}, 32'd3);
    check("memwait_no_timeout", {31'd0, mem_timeout}, 32'd0);
    tick();
    clear_inputs();
    tick();

    // Timeout after 8 consecutive waits, sticky until reset.
    MEM_memEn = 1; dmem_ready = 0;
    repeat (7) tick();
    check("timeout_7", {31'd0, mem_timeout}, 32'd0);
    tick();
    check("timeout_8", {31'd0, mem_timeout}, 32'd1);
    check("timeout_still_stall", ctl(), 32'b110011);
    dmem_ready = 1;
    tick();
    check("timeout_sticky", {31'd0, mem_timeout}, 32'd1);
    clear_inputs();
    reset = 1;
    tick();
    reset = 0;
    settle();
    check("timeout_cleared", {31'd0, mem_timeout}, 32'd0);

    // Reset in the middle of a memory wait.
    MEM_memEn = 1; dmem_ready = 0;
    repeat (3) tick();
    check("mid_state", {30'd0, hdu_state}, 32'd3);
    reset = 1;
    settle();
    check("mid_rst_ctl", ctl(), 32'h00);
    check("mid_rst_state", {30'd0, hdu_state}, 32'd0);
    tick();
    check("mid_rst_ctl_2", ctl(), 32'h00);
    reset = 0;
    settle();
    check("mid_rel_state", {30'd0, hdu_state}, 32'd0);
    check("mid_rel_ctl", ctl(), 32'b110011);
    repeat (7) tick();
    check("mid_restart_7", {31'd0, mem_timeout}, 32'd0);
    tick();
    check("mid_restart_8", {31'd0, mem_timeout}, 32'd1);
    clear_inputs();
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
